seg_scan_driver: RTL and testbench

Time-multiplexed display driver placed directly downstream of the calculator's five segment decoders. It snapshots the five 7-bit segment patterns once per frame and drives them one digit at a time onto a shared segment bus with one-hot digit enables, so a five-digit common-segment FND module needs 7 + 5 pins instead of 35. Optional inter-digit blanking suppresses ghosting during digit switch-over.

---
 rtl/calc_disp_pkg.sv | 25 ++
 rtl/scan_prescaler.sv | 49 ++++
 rtl/seg_scan_driver.sv | 97 +++++++++
 tb/tb_seg_scan_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator display path: digit count, segment
// width, the blank pattern and a one-hot digit-select helper.
package calc_disp_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int SEG_W      = 7;
  localparam int IDX_W      = 3;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam seg_t SEG_BLANK = 7'b0;
  localparam idx_t LAST_IDX  = idx_t'(NUM_DIGITS - 1);

  // One-hot digit enable for a digit index; out-of-range indices give all-off.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input idx_t idx);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == idx_t'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timing for the scan driver: counts SCAN_DIV cycles per digit slot and
// steps the digit index 0..4. Exports slot-wrap, frame-boundary and in-blank
// strobes, all decoded from the current counter state.
// Optional blanking is compiled in with `define SEG_SCAN_BLANK_EN.
module scan_prescaler
  import calc_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  output idx_t idx,
  output logic slot_wrap,
  output logic frame_bnd,
  output logic in_blank
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [CNT_W-1:0] pre_cnt;

  assign slot_wrap = (pre_cnt == CNT_LAST);
  assign frame_bnd = slot_wrap && (idx == LAST_IDX);
  // The compare folds away when blanking is not compiled in.
  assign in_blank  = BLANK_ON && (pre_cnt < BLANK_END);

  // Prescaler and digit index: idx advances only when the slot counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (slot_wrap) begin
      pre_cnt <= '0;
      idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 5-digit segment driver. Snapshots seg1..seg5 into shadow
// registers at each frame boundary (unless hold is high), then drives one
// digit per slot onto the shared segment bus with a one-hot digit enable.
// Optional inter-digit blanking is compiled in with `define SEG_SCAN_BLANK_EN.
module seg_scan_driver
  import calc_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      seg1,
  input  logic [SEG_W-1:0]      seg2,
  input  logic [SEG_W-1:0]      seg3,
  input  logic [SEG_W-1:0]      seg4,
  input  logic [SEG_W-1:0]      seg5,
  input  logic                  hold,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_tick
);

  idx_t idx;
  logic frame_bnd;
  logic in_blank;
  // Slot-wrap strobe is not needed here; the boundary strobe already covers it.
  logic slot_wrap_unused;

  seg_t shadow [NUM_DIGITS];
  logic load_pend;
  logic load_p0;
  seg_t cur_seg_p0;
  logic snap_vld_p1;

  scan_prescaler #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .slot_wrap(slot_wrap_unused),
    .frame_bnd(frame_bnd),
    .in_blank (in_blank)
  );

  // p0: snapshot decision; the post-reset load ignores hold.
  assign load_p0 = load_pend || (frame_bnd && !hold);

  // Select the shadow of the digit currently being scanned.
  always_comb begin
    cur_seg_p0 = SEG_BLANK;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == idx_t'(k)) cur_seg_p0 = shadow[k];
    end
  end

  // Whole-frame snapshot: all five shadows load together so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= SEG_BLANK;
      load_pend   <= 1'b1;
      snap_vld_p1 <= 1'b0;
    end else begin
      load_pend   <= 1'b0;
      snap_vld_p1 <= load_p0;
      if (load_p0) begin
        shadow[0] <= seg1;
        shadow[1] <= seg2;
        shadow[2] <= seg3;
        shadow[3] <= seg4;
        shadow[4] <= seg5;
      end
    end
  end

  // p1 -> outputs: registered bus/enables; frame_tick marks the first cycle a
  // new snapshot is on the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out    <= SEG_BLANK;
      dig_en     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap_vld_p1;
      if (in_blank) begin
        seg_out <= SEG_BLANK;
        dig_en  <= '0;
      end else begin
        seg_out <= cur_seg_p0;
        dig_en  <= digit_onehot(idx);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV = 4, BLANK_CYCLES = 1.
// n counts rising edges since the last reset release; the outputs seen after
// edge n reflect the internal state at position n-1 (slot (n-1)/4, cycle (n-1)%4).
module tb_seg_scan_driver;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int FRAME        = 5 * SCAN_DIV;

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg1 = 7'h00;
  logic [6:0] seg2 = 7'h00;
  logic [6:0] seg3 = 7'h00;
  logic [6:0] seg4 = 7'h00;
  logic [6:0] seg5 = 7'h00;
  logic       hold = 1'b0;
  logic [6:0] seg_out;
  logic [4:0] dig_en;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [6:0] exp_sh [5];

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .seg4      (seg4),
    .seg5      (seg5),
    .hold      (hold),
    .seg_out   (seg_out),
    .dig_en    (dig_en),
    .frame_tick(frame_tick)
  );

  task automatic advance();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic bit is_blank(int k);
    return BLANK_ON && (((k - 1) % SCAN_DIV) < BLANK_CYCLES);
  endfunction

  function automatic logic [4:0] want_dig(int k);
    logic [4:0] one;
    one = 5'b00001;
    if (is_blank(k)) return 5'b00000;
    return one << (((k - 1) / SCAN_DIV) % 5);
  endfunction

  function automatic logic [6:0] want_seg(int k);
    if (is_blank(k)) return 7'h00;
    return exp_sh[((k - 1) / SCAN_DIV) % 5];
  endfunction

  task automatic test_reset();
    seg1 = 7'h06; seg2 = 7'h5B; seg3 = 7'h4F; seg4 = 7'h66; seg5 = 7'h6D;
    hold = 1'b0;
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dig_en !== 5'b0) begin errors++; $display("FAIL reset_dig_en got %b want 00000", dig_en); end
    checks++;
    if (seg_out !== 7'h00) begin errors++; $display("FAIL reset_seg_out got %h want 00", seg_out); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
    for (int i = 0; i < 5; i++) exp_sh[i] = 7'h00;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    // Edge 1 loads the shadows; its outputs still show the reset shadows.
    for (int i = 0; i < FRAME; i++) begin
      advance();
      checks++;
      if (dig_en !== want_dig(n)) begin errors++; $display("FAIL post_reset_dig_en n=%0d got %b want %b", n, dig_en, want_dig(n)); end
      checks++;
      if (seg_out !== want_seg(n)) begin errors++; $display("FAIL post_reset_seg_out n=%0d got %h want %h", n, seg_out, want_seg(n)); end
      checks++;
      if (frame_tick !== (n == 2)) begin errors++; $display("FAIL post_reset_tick n=%0d got %b want %b", n, frame_tick, (n == 2)); end
      if (n == 1) begin
        exp_sh[0] = 7'h06; exp_sh[1] = 7'h5B; exp_sh[2] = 7'h4F; exp_sh[3] = 7'h66; exp_sh[4] = 7'h6D;
      end
    end
  endtask

  // Second frame: continuous scan, including the 10000 -> 00001 wrap.
  task automatic test_scan();
    for (int i = 0; i < FRAME + 4; i++) begin
      advance();
      checks++;
      if (dig_en !== want_dig(n)) begin errors++; $display("FAIL scan_dig_en n=%0d got %b want %b", n, dig_en, want_dig(n)); end
      checks++;
      if (seg_out !== want_seg(n)) begin errors++; $display("FAIL scan_seg_out n=%0d got %h want %h", n, seg_out, want_seg(n)); end
      checks++;
      if (frame_tick !== (n == 21 || n == 41)) begin errors++; $display("FAIL scan_tick n=%0d got %b want %b", n, frame_tick, (n == 21 || n == 41)); end
    end
  endtask

  // seg1 changes mid-frame (after edge 45); the boundary at edge 60 captures it.
  task automatic test_mid_frame_change();
    advance();
    seg1 = 7'h3F;
    while (n < 64) begin
      advance();
      checks++;
      if (seg_out !== want_seg(n)) begin errors++; $display("FAIL midframe_seg_out n=%0d got %h want %h", n, seg_out, want_seg(n)); end
      checks++;
      if (dig_en !== want_dig(n)) begin errors++; $display("FAIL midframe_dig_en n=%0d got %b want %b", n, dig_en, want_dig(n)); end
      checks++;
      if (frame_tick !== (n == 61)) begin errors++; $display("FAIL midframe_tick n=%0d got %b want %b", n, frame_tick, (n == 61)); end
      if (n == 60) exp_sh[0] = 7'h3F;
    end
  endtask

  // hold across the boundaries at edges 80 and 100, released mid-frame; the
  // boundary at edge 120 picks up seg3 = 7F.
  task automatic test_hold();
    hold = 1'b1;
    seg3 = 7'h7F;
    while (n < 132) begin
      advance();
      checks++;
      if (seg_out !== want_seg(n)) begin errors++; $display("FAIL hold_seg_out n=%0d got %h want %h", n, seg_out, want_seg(n)); end
      checks++;
      if (dig_en !== want_dig(n)) begin errors++; $display("FAIL hold_dig_en n=%0d got %b want %b", n, dig_en, want_dig(n)); end
      checks++;
      if (frame_tick !== (n == 121)) begin errors++; $display("FAIL hold_tick n=%0d got %b want %b", n, frame_tick, (n == 121)); end
      if (n == 105) hold = 1'b0;
      if (n == 120) exp_sh[2] = 7'h7F;
    end
  endtask

  // hold dropped during the boundary cycle itself (state before edge 140).
  task automatic test_hold_release_on_boundary();
    hold = 1'b1;
    seg5 = 7'h71;
    while (n < 160) begin
      advance();
      checks++;
      if (seg_out !== want_seg(n)) begin errors++; $display("FAIL bnd_release_seg_out n=%0d got %h want %h", n, seg_out, want_seg(n)); end
      checks++;
      if (frame_tick !== (n == 141)) begin errors++; $display("FAIL bnd_release_tick n=%0d got %b want %b", n, frame_tick, (n == 141)); end
      if (n == 139) hold = 1'b0;
      if (n == 140) exp_sh[4] = 7'h71;
    end
  endtask

  // Asynchronous reset in slot 2, cycle 2, then a fresh scan with new data.
  task automatic test_async_reset();
    while (n < 170) advance();
    checks++;
    if (dig_en !== 5'b00100) begin errors++; $display("FAIL pre_async_dig_en got %b want 00100", dig_en); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dig_en !== 5'b0) begin errors++; $display("FAIL async_dig_en got %b want 00000", dig_en); end
    checks++;
    if (seg_out !== 7'h00) begin errors++; $display("FAIL async_seg_out got %h want 00", seg_out); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL async_tick got %b want 0", frame_tick); end
    seg1 = 7'h77; seg2 = 7'h7C; seg3 = 7'h39; seg4 = 7'h5E; seg5 = 7'h79;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) exp_sh[i] = 7'h00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    // Post-reset load happens even though hold is high.
    while (n < 2 * FRAME) begin
      advance();
      checks++;
      if (dig_en !== want_dig(n)) begin errors++; $display("FAIL restart_dig_en n=%0d got %b want %b", n, dig_en, want_dig(n)); end
      checks++;
      if (seg_out !== want_seg(n)) begin errors++; $display("FAIL restart_seg_out n=%0d got %h want %h", n, seg_out, want_seg(n)); end
      checks++;
      if (frame_tick !== (n == 2)) begin errors++; $display("FAIL restart_tick n=%0d got %b want %b", n, frame_tick, (n == 2)); end
      if (n == 1) begin
        exp_sh[0] = 7'h77; exp_sh[1] = 7'h7C; exp_sh[2] = 7'h39; exp_sh[3] = 7'h5E; exp_sh[4] = 7'h79;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_frame_change();
    test_hold();
    test_hold_release_on_boundary();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
